// File: rtl/iq_accumulator_pkg.sv
// Shared types, defaults and the saturating adder for the I/Q integrator.
package iq_pkg;

   localparam int LANES_DEF  = 5;
   localparam int DATA_W_DEF = 16;
   localparam int ACC_W_DEF  = 32;
   localparam int LEN_W_DEF  = 11;

   typedef enum logic [1:0] {IDLE, INTEGRATE, HOLD} state_e;

   typedef struct packed {
      logic signed [63:0] sum;
      logic               clamp;
   } sat_res_t;

   // Operands arrive sign-extended to 64 bits, so the raw sum cannot wrap for w <= 62.
   function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                        input logic signed [63:0] b,
                                        input int                 w);
      logic signed [63:0] full, hi, lo;
      sat_res_t           r;
      full    = a + b;
      hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      r.sum   = full;
      r.clamp = 1'b0;
      if (full > hi) begin
         r.sum   = hi;
         r.clamp = 1'b1;
      end else if (full < lo) begin
         r.sum   = lo;
         r.clamp = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/iq_accumulator_lane_sum.sv
// Combinational masked sum of one channel's lanes, sign-extended to hold LANES full-scale samples.
module lane_sum
   import iq_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [LANES-1:0]                         lane_valid,
   input  logic [LANES*DATA_W-1:0]                  data,
   output logic signed [DATA_W+$clog2(LANES)-1:0]   sum
);

   localparam int SUM_W = DATA_W + $clog2(LANES);

   logic signed [DATA_W-1:0] smp;

   always_comb begin
      sum = '0;
      smp = '0;
      for (int k = 0; k < LANES; k++) begin
         smp = data[k*DATA_W +: DATA_W];
         if (lane_valid[k]) sum = sum + SUM_W'(smp);
      end
   end

endmodule

// File: rtl/iq_accumulator.sv
// Multi-lane I/Q integrator with saturation and valid/ready result handoff.
// Optional linear classifier stage enabled by IQ_ACCUMULATOR_CLASSIFIER_EN.
module iq_accumulator
   import iq_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                      clk_100,
   input  logic                      reset,
   input  logic                      start,
   input  logic [LEN_W-1:0]          sample_length,
   input  logic [LANES-1:0]          lane_valid,
   input  logic [LANES*DATA_W-1:0]   data_i_rot,
   input  logic [LANES*DATA_W-1:0]   data_q_rot,
   input  logic                      iq_ready,
   output logic                      iq_valid,
   output logic signed [ACC_W-1:0]   i_val,
   output logic signed [ACC_W-1:0]   q_val,
   output logic                      sat,
   output logic                      busy,
   output logic                      start_drop
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
   ,input  logic signed [15:0]       class_w_i
   ,input  logic signed [15:0]       class_w_q
   ,input  logic signed [ACC_W+16:0] class_thresh
   ,output logic                     class_bit
`endif
);

   localparam int SUM_W = DATA_W + $clog2(LANES);

   logic signed [SUM_W-1:0] sum_i, sum_q;
   state_e                  state_q, state_d;
   logic [LEN_W-1:0]        len_q, len_d, cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic                    sat_q, sat_d, drop_q, drop_d;
   logic                    take_start, hs;
   sat_res_t                ri, rq;

   lane_sum #(.LANES(LANES), .DATA_W(DATA_W)) u_sum_i (
      .lane_valid(lane_valid), .data(data_i_rot), .sum(sum_i));
   lane_sum #(.LANES(LANES), .DATA_W(DATA_W)) u_sum_q (
      .lane_valid(lane_valid), .data(data_q_rot), .sum(sum_q));

   assign hs = iq_valid && iq_ready;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      acc_i_d    = acc_i_q;
      acc_q_d    = acc_q_q;
      sat_d      = sat_q;
      drop_d     = 1'b0;
      take_start = 1'b0;
      ri         = sat_add(64'(acc_i_q), 64'(sum_i), ACC_W);
      rq         = sat_add(64'(acc_q_q), 64'(sum_q), ACC_W);
      unique case (state_q)
         IDLE: take_start = start;
         INTEGRATE: begin
            acc_i_d = ACC_W'(ri.sum);
            acc_q_d = ACC_W'(rq.sum);
            sat_d   = sat_q | ri.clamp | rq.clamp;
            cnt_d   = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) state_d = HOLD;
            drop_d  = start;
         end
         HOLD: begin
            if (hs) begin
               state_d    = IDLE;
               take_start = start;
            end else begin
               drop_d = start;
            end
         end
         default: state_d = IDLE;
      endcase
      // A start alongside the HOLD handshake behaves exactly like a start from IDLE.
      if (take_start) begin
         len_d   = sample_length;
         cnt_d   = '0;
         acc_i_d = '0;
         acc_q_d = '0;
         sat_d   = 1'b0;
         state_d = (sample_length == '0) ? HOLD : INTEGRATE;
      end
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         acc_i_q <= '0;
         acc_q_q <= '0;
         sat_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         sat_q   <= sat_d;
         drop_q  <= drop_d;
      end
   end

   assign i_val      = acc_i_q;
   assign q_val      = acc_q_q;
   assign sat        = sat_q;
   assign busy       = (state_q != IDLE);
   assign start_drop = drop_q;

`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
   localparam int CLS_W = ACC_W + 17;

   logic                    cls_done_q, cls_done_d, class_bit_q, class_bit_d;
   logic signed [CLS_W-1:0] cls_sum;

   // First HOLD cycle evaluates the score; the result is presented one cycle later.
   always_comb begin
      cls_sum     = CLS_W'(class_w_i) * CLS_W'(acc_i_q) + CLS_W'(class_w_q) * CLS_W'(acc_q_q);
      cls_done_d  = (state_q == HOLD) && !hs;
      class_bit_d = class_bit_q;
      if (state_q == HOLD && !cls_done_q) class_bit_d = (cls_sum > class_thresh);
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         cls_done_q  <= 1'b0;
         class_bit_q <= 1'b0;
      end else begin
         cls_done_q  <= cls_done_d;
         class_bit_q <= class_bit_d;
      end
   end

   assign iq_valid  = (state_q == HOLD) && cls_done_q;
   assign class_bit = class_bit_q;
`else
   assign iq_valid  = (state_q == HOLD);
`endif

endmodule

// File: tb/tb_iq_accumulator.sv
// Directed self-checking bench for iq_accumulator (default and ACC_W=20 instances).
module tb_iq_accumulator;

   localparam int LANES = 5, DATA_W = 16, ACC_W = 32, LEN_W = 11, ACC_S = 20;
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic                    clk_100 = 1'b0;
   logic                    reset, start, iq_ready;
   logic [LEN_W-1:0]        sample_length;
   logic [LANES-1:0]        lane_valid;
   logic [LANES*DATA_W-1:0] data_i_rot, data_q_rot;
   logic                    iq_valid, sat, busy, start_drop;
   logic signed [ACC_W-1:0] i_val, q_val;
   logic                    iq_valid_s, sat_s, busy_s, start_drop_s;
   logic signed [ACC_S-1:0] i_val_s, q_val_s;
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
   logic signed [15:0]       class_w_i, class_w_q;
   logic signed [ACC_W+16:0] class_thresh;
   logic signed [ACC_S+16:0] class_thresh_s;
   logic                     class_bit, class_bit_s;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_100 = ~clk_100;

   iq_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk_100(clk_100), .reset(reset), .start(start), .sample_length(sample_length),
      .lane_valid(lane_valid), .data_i_rot(data_i_rot), .data_q_rot(data_q_rot),
      .iq_ready(iq_ready), .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val),
      .sat(sat), .busy(busy), .start_drop(start_drop)
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
      , .class_w_i(class_w_i), .class_w_q(class_w_q), .class_thresh(class_thresh),
      .class_bit(class_bit)
`endif
   );

   iq_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_S), .LEN_W(LEN_W)) dut_s (
      .clk_100(clk_100), .reset(reset), .start(start), .sample_length(sample_length),
      .lane_valid(lane_valid), .data_i_rot(data_i_rot), .data_q_rot(data_q_rot),
      .iq_ready(iq_ready), .iq_valid(iq_valid_s), .i_val(i_val_s), .q_val(q_val_s),
      .sat(sat_s), .busy(busy_s), .start_drop(start_drop_s)
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
      , .class_w_i(class_w_i), .class_w_q(class_w_q), .class_thresh(class_thresh_s),
      .class_bit(class_bit_s)
`endif
   );

   task automatic step();
      @(posedge clk_100);
      #1;
   endtask

   task automatic fill(input int iv, input int qv);
      for (int k = 0; k < LANES; k++) begin
         data_i_rot[k*DATA_W +: DATA_W] = 16'(iv);
         data_q_rot[k*DATA_W +: DATA_W] = 16'(qv);
      end
   endtask

   // Returns the cycle (counted from 1 = first beat) on which iq_valid is seen; 300 on timeout.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!iq_valid && lat < 300) begin
         step();
         lat++;
      end
   endtask

   task automatic run(input int n, output int lat);
      start = 1'b1;
      sample_length = LEN_W'(n);
      step();
      start = 1'b0;
      wait_valid(lat);
   endtask

   task automatic accept();
      iq_ready = 1'b1;
      step();
      iq_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", iq_valid); end
      checks++; if (i_val !== 0 || q_val !== 0) begin errors++; $display("FAIL reset_iq: got %0d/%0d expected 0/0", i_val, q_val); end
      checks++; if (sat !== 1'b0 || busy !== 1'b0 || start_drop !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%0d busy=%0d drop=%0d expected 0", sat, busy, start_drop); end
      checks++; if (iq_valid_s !== 1'b0 || i_val_s !== 0 || sat_s !== 1'b0) begin errors++; $display("FAIL reset_sat_inst: got v=%0d i=%0d s=%0d expected 0", iq_valid_s, i_val_s, sat_s); end
   endtask

   task automatic test_basic();
      int lat;
      lane_valid = '1;
      fill(100, -50);
      run(4, lat);
      checks++; if (lat !== 5 + EXTRA) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, 5 + EXTRA); end
      checks++; if (i_val !== 2000) begin errors++; $display("FAIL basic_i: got %0d expected 2000", i_val); end
      checks++; if (q_val !== -1000) begin errors++; $display("FAIL basic_q: got %0d expected -1000", q_val); end
      checks++; if (sat !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_flags: got sat=%0d busy=%0d expected 0/1", sat, busy); end
      accept();
      checks++; if (iq_valid !== 1'b0 || busy !== 1'b0 || i_val !== 2000) begin errors++; $display("FAIL basic_after_accept: got v=%0d busy=%0d i=%0d expected 0/0/2000", iq_valid, busy, i_val); end
   endtask

   task automatic test_lane_mask();
      int lat;
      lane_valid = 5'b00101;
      for (int k = 0; k < LANES; k++) begin
         data_i_rot[k*DATA_W +: DATA_W] = (k == 0 || k == 2) ? 16'd7 : 16'd1000;
         data_q_rot[k*DATA_W +: DATA_W] = 16'(k + 1);
      end
      run(3, lat);
      checks++; if (lat !== 4 + EXTRA) begin errors++; $display("FAIL mask_latency: got %0d expected %0d", lat, 4 + EXTRA); end
      checks++; if (i_val !== 42 || q_val !== 12) begin errors++; $display("FAIL mask_sums: got %0d/%0d expected 42/12", i_val, q_val); end
      accept();
      run(0, lat);
      checks++; if (lat !== 1 + EXTRA) begin errors++; $display("FAIL zero_len_latency: got %0d expected %0d", lat, 1 + EXTRA); end
      checks++; if (i_val !== 0 || q_val !== 0) begin errors++; $display("FAIL zero_len_sums: got %0d/%0d expected 0/0", i_val, q_val); end
      accept();
   endtask

   task automatic test_saturation();
      int lat;
      lane_valid = '1;
      fill(32767, 0);
      run(8, lat);
      checks++; if (i_val_s !== 524287 || sat_s !== 1'b1) begin errors++; $display("FAIL sat_pos: got %0d sat=%0d expected 524287 sat=1", i_val_s, sat_s); end
      checks++; if (i_val !== 1310680 || sat !== 1'b0) begin errors++; $display("FAIL wide_pos: got %0d sat=%0d expected 1310680 sat=0", i_val, sat); end
      accept();
      fill(-32767, 0);
      run(8, lat);
      checks++; if (i_val_s !== -524288 || sat_s !== 1'b1 || q_val_s !== 0) begin errors++; $display("FAIL sat_neg: got %0d sat=%0d q=%0d expected -524288 sat=1 q=0", i_val_s, sat_s, q_val_s); end
      checks++; if (i_val !== -1310680) begin errors++; $display("FAIL wide_neg: got %0d expected -1310680", i_val); end
      accept();
   endtask

   task automatic test_handshake();
      int lat;
      int bad;
      fill(3, -2);
      run(2, lat);
      checks++; if (lat !== 3 + EXTRA || i_val !== 30 || q_val !== -20) begin errors++; $display("FAIL hs_result: got lat=%0d %0d/%0d expected %0d 30/-20", lat, i_val, q_val, 3 + EXTRA); end
      checks++; if (sat_s !== 1'b0) begin errors++; $display("FAIL sat_cleared: got %0d expected 0", sat_s); end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!iq_valid || i_val !== 30 || q_val !== -20) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hs_hold_stable: got %0d bad cycles expected 0", bad); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (start_drop !== 1'b1) begin errors++; $display("FAIL hold_start_drop: got %0d expected 1", start_drop); end
      checks++; if (iq_valid !== 1'b1 || i_val !== 30) begin errors++; $display("FAIL hold_no_restart: got v=%0d i=%0d expected 1/30", iq_valid, i_val); end
      step();
      checks++; if (start_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %0d expected 0", start_drop); end
      fill(1, 1);
      sample_length = 11'd1;
      start = 1'b1;
      iq_ready = 1'b1;
      step();
      start = 1'b0;
      iq_ready = 1'b0;
      checks++; if (busy !== 1'b1 || iq_valid !== 1'b0) begin errors++; $display("FAIL b2b_restart: got busy=%0d v=%0d expected 1/0", busy, iq_valid); end
      wait_valid(lat);
      checks++; if (lat !== 2 + EXTRA || i_val !== 5 || q_val !== 5) begin errors++; $display("FAIL b2b_result: got lat=%0d %0d/%0d expected %0d 5/5", lat, i_val, q_val, 2 + EXTRA); end
      accept();
   endtask

   task automatic test_reset_mid();
      int lat;
      int bad;
      fill(10, 20);
      start = 1'b1;
      sample_length = 11'd10;
      step();
      start = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (iq_valid !== 1'b0 || i_val !== 0 || q_val !== 0) begin errors++; $display("FAIL midreset_iq: got v=%0d %0d/%0d expected 0 0/0", iq_valid, i_val, q_val); end
      checks++; if (busy !== 1'b0 || sat !== 1'b0 || start_drop !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%0d sat=%0d drop=%0d expected 0", busy, sat, start_drop); end
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (iq_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_no_result: got %0d bad cycles expected 0", bad); end
      run(3, lat);
      checks++; if (lat !== 4 + EXTRA || i_val !== 150 || q_val !== 300) begin errors++; $display("FAIL postreset_run: got lat=%0d %0d/%0d expected %0d 150/300", lat, i_val, q_val, 4 + EXTRA); end
      accept();
   endtask

`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
   task automatic test_classifier();
      int lat;
      fill(1, 0);
      run(2, lat);
      checks++; if (lat !== 4 || class_bit !== 1'b1 || i_val !== 10) begin errors++; $display("FAIL class_pos: got lat=%0d bit=%0d i=%0d expected 4 1 10", lat, class_bit, i_val); end
      accept();
      fill(-1, 0);
      run(2, lat);
      checks++; if (lat !== 4 || class_bit !== 1'b0 || i_val !== -10) begin errors++; $display("FAIL class_neg: got lat=%0d bit=%0d i=%0d expected 4 0 -10", lat, class_bit, i_val); end
      accept();
   endtask
`endif

   initial begin
      reset = 1'b1;
      start = 1'b0;
      iq_ready = 1'b0;
      sample_length = '0;
      lane_valid = '0;
      data_i_rot = '0;
      data_q_rot = '0;
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
      class_w_i = 16'sd1;
      class_w_q = 16'sd0;
      class_thresh = '0;
      class_thresh_s = '0;
`endif
      test_reset();
      test_basic();
      test_lane_mask();
      test_saturation();
      test_handshake();
      test_reset_mid();
`ifdef IQ_ACCUMULATOR_CLASSIFIER_EN
      test_classifier();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iq_accumulator.md
# iq_accumulator

Parametrised multi-lane I/Q integrator for qubit readout. Each clock it takes `LANES` rotated I/Q samples from the demodulation multiplier stage, sums the lanes flagged valid, and accumulates them with saturation over a configured number of clock beats. The finished (I, Q) pair is handed downstream (binning, classifier or data dump) over a valid/ready handshake. It sits between the rotation multiplier and the analysis stage and supersedes the fixed 5-lane integrator.

## Interface

**Parameters**
- `LANES`, default 5: samples delivered per clock.
- `DATA_W`, default 16: signed sample width.
- `ACC_W`, default 32: signed accumulator width. Must satisfy ACC_W ≥ DATA_W + clog2(LANES).
- `LEN_W`, default 11: width of the beat-count field.

**Ports** (reset is synchronous, active-high; clock is `clk_100`)
- `clk_100`, in, 1: system clock.
- `reset`, in, 1: synchronous active-high reset.
- `start`, in, 1: single-cycle pulse that begins an integration.
- `sample_length`, in, LEN_W: number of beats to integrate. Latched on an accepted start.
- `lane_valid`, in, LANES: per-lane sample strobe. Bit k qualifies lane k.
- `data_i_rot`, in, LANES*DATA_W: signed I samples. Lane k is at `[k*DATA_W +: DATA_W]`.
- `data_q_rot`, in, LANES*DATA_W: signed Q samples, same packing.
- `iq_ready`, in, 1: downstream accepts the result.
- `iq_valid`, out, 1: result available.
- `i_val`, out, ACC_W: signed integrated I.
- `q_val`, out, ACC_W: signed integrated Q.
- `sat`, out, 1: sticky flag; set if any add clamped during this measurement.
- `busy`, out, 1: high in INTEGRATE or HOLD.
- `start_drop`, out, 1: one-cycle pulse when a start is ignored.

## Operation

**Reset**
- Outputs: `iq_valid`=0, `i_val`=0, `q_val`=0, `sat`=0, `busy`=0, `start_drop`=0.
- State goes to IDLE; the beat counter is cleared.
- Reset asserted mid-operation aborts the measurement immediately; no result is produced.

**States**
- IDLE:
  - On `start`: latch `sample_length` into `len_q`, clear the accumulators, `sat` and the counter.
  - If `sample_length`==0, go directly to HOLD with zero sums. Otherwise go to INTEGRATE.
- INTEGRATE:
  - Each cycle, compute the lane sum: the sum of valid lanes only, sign-extended, width DATA_W+clog2(LANES).
  - Add the lane sum to each accumulator.
  - Saturate to the signed ACC_W limits [-2^(ACC_W-1), 2^(ACC_W-1)-1]; set `sat` if either channel clamps.
  - Increment the counter. After the beat with counter == `len_q`-1, go to HOLD.
  - A beat with `lane_valid`=0 still counts but adds nothing.
- HOLD:
  - `iq_valid`=1; `i_val`, `q_val` and `sat` are stable.
  - On `iq_valid && iq_ready`, return to IDLE.
  - If `start` is high in the same cycle as the accepted handshake, go straight to INTEGRATE (treated as an IDLE start, back-to-back).

**Ignored starts**
- A `start` in INTEGRATE, or in HOLD without a handshake, is ignored and pulses `start_drop` on the next cycle.

**Stability**
- `i_val` and `q_val` change only in INTEGRATE or at the clear on start.
- Between measurements they hold the last result.

## Timing

- Start is sampled at cycle 0. Beats 1..N sample the inputs on cycles 1..N.
- `iq_valid` rises at cycle N+1, giving a latency of N+1 clocks.
- With N=0, `iq_valid` rises at cycle 1 with zero sums.
- Data on the cycle of `start` is not integrated.
- `iq_valid` holds indefinitely until `iq_ready`. No result is ever dropped or overwritten.
- Back-to-back throughput is one measurement per N+1 cycles when `iq_ready` is tied high.

## Configuration

Macro: `IQ_ACCUMULATOR_CLASSIFIER_EN`.

**Defined**
- Added inputs:
  - `class_w_i`, signed 16.
  - `class_w_q`, signed 16.
  - `class_thresh`, signed ACC_W+17.
- Added output: `class_bit`, 1.
- On entering HOLD, one extra pipeline cycle computes `class_w_i*i_val + class_w_q*q_val`:
  - Full precision ACC_W+17 bits.
  - `class_bit` = 1 when the sum exceeds `class_thresh` (strictly greater).
- `iq_valid` rises at N+2, and `class_bit` is valid with it.
- `class_bit` resets to 0.

**Undefined**
- The added ports and logic are absent; latency is N+1.

## Structure

- Package `iq_pkg`:
  - State enum (IDLE, INTEGRATE, HOLD).
  - Signed saturating-add function parameterised by width.
  - Default constants for `LANES`, `DATA_W`, `ACC_W` and `LEN_W`.
- Sub-module `lane_sum` (params LANES, DATA_W):
  - Combinational masked adder tree.
  - Two instances, one for I and one for Q.
- The top level holds the FSM, counter, accumulators, handshake and optional classifier.

## Test plan

- **Basic:** LANES=5, N=4, all lanes valid, I=100 and Q=-50 every lane → `iq_valid` at cycle 5, `i_val`=2000, `q_val`=-1000, `sat`=0.
- **Lane mask:** `lane_valid`=5'b00101, I=7 → `i_val`=14·N. Also apply N=0 → `iq_valid` at cycle 1, sums 0.
- **Saturation:** ACC_W=20, I=32767 on all 5 lanes, N=8 → `i_val`=524287, `sat`=1. Same test with negated data → -524288.
- **Handshake:** hold `iq_ready`=0 for 10 cycles → outputs stable, `iq_valid` stays 1. Pulse `start` during HOLD → `start_drop`=1, no restart. Apply `start` together with `iq_ready`=1 → new integration begins without passing through IDLE.
- **Reset:** assert `reset` at beat 2 of N=10 → next cycle all outputs 0, IDLE. A following start with N=3 yields the correct sums.
- **Classifier (macro defined):** w_i=1, w_q=0, thresh=0, I=+1/-1 runs → `class_bit`=1/0, `iq_valid` at N+2.
